// File: rtl/core_mem_seq.sv
// Multi-cycle sequencer sharing one single-port bus between instruction fetch and
// data load/store, with a bus watchdog and a debug halt at instruction boundaries.
module core_mem_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] alu_res,
  input  logic [31:0] write_data,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [3:0]  wstrb,
  input  logic        halt_req,
  output logic [31:0] instr,
  output logic [31:0] ram_read_data,
  output logic        core_en,
  output logic        halted,
  output logic        bus_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam logic [15:0] Timeout = 16'(TIMEOUT);
  localparam logic [31:0] Nop     = 32'h0000_0013;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StData,
    StCommit,
    StHalt,
    StFault
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q;
  logic        in_fetch, in_data;

  assign in_fetch = (state_q == StFetch);
  assign in_data  = (state_q == StData);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   state_d = halt_req ? StHalt : StFetch;
      StFetch: begin
        if (bus_ack)                state_d = StExec;
        else if (cnt_q == Timeout)  state_d = StFault;
      end
      StExec:   state_d = (mem_we || mem_re) ? StData : StCommit;
      StData: begin
        if (bus_ack)                state_d = StCommit;
        else if (cnt_q == Timeout)  state_d = StFault;
      end
      StCommit: state_d = halt_req ? StHalt : StFetch;
      StHalt: begin
        if (!halt_req)              state_d = StFetch;
      end
      StFault:  state_d = StFault;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      instr         <= Nop;
      ram_read_data <= '0;
      core_en       <= 1'b0;
      halted        <= 1'b0;
      bus_fault     <= 1'b0;
      bus_req       <= 1'b0;
    end else begin
      state_q   <= state_d;
      core_en   <= (state_d == StCommit);
      halted    <= (state_d == StHalt);
      bus_fault <= (state_d == StFault);
      bus_req   <= (state_d == StFetch) || (state_d == StData);
      // Counter restarts whenever a transfer phase is (re)entered.
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if ((in_fetch || in_data) && !bus_ack) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (in_fetch && bus_ack) begin
        instr <= bus_rdata;
      end
      // A simultaneous load/store request is treated as a store.
      if (in_data && bus_ack && !mem_we) begin
        ram_read_data <= bus_rdata;
      end
    end
  end

  always_comb begin
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wstrb = '0;
    if (in_fetch) begin
      bus_addr = {pc[31:2], 2'b00};
    end else if (in_data) begin
      bus_addr  = {alu_res[31:2], 2'b00};
      bus_we    = mem_we;
      bus_wdata = write_data;
      bus_wstrb = mem_we ? wstrb : 4'b0000;
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{pc[1:0], alu_res[1:0]};

endmodule
